saturating_narrow: RTL
======================

SATURATING_NARROW -- requirements
Module: saturating_narrow

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 Parameter IN_W SHALL default to 16 and SHALL be the signed input width.
REQ-003 Parameter OUT_W SHALL default to 8 and SHALL be the signed output width; legal only when 2 <= OUT_W < IN_W.
REQ-004 Port clk_i SHALL be an input, 1 bit wide, and is the only clock.
REQ-005 Port rst_i SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-006 Port in_valid_i SHALL be an input, 1 bit wide, and flags an input word as present.
REQ-007 Port in_data_i SHALL be an input, IN_W bits wide, and carries the two's-complement input.
REQ-008 Port in_ready_o SHALL be an output, 1 bit wide, and indicates the block accepts the input this cycle.
REQ-009 Port sat_mode_i SHALL be an input, 1 bit wide: 1 = saturate, 0 = wrap (plain truncation).
REQ-010 Port out_valid_o SHALL be an output, 1 bit wide, and flags an output word as present.
REQ-011 Port out_data_o SHALL be an output, OUT_W bits wide, and carries the narrowed two's-complement result.
REQ-012 Port out_ovf_o SHALL be an output, 1 bit wide, and is set when the input did not fit in OUT_W signed bits.
REQ-013 Port out_ready_i SHALL be an input, 1 bit wide, and indicates the consumer accepts the output.
REQ-014 Port cnt_clr_i SHALL be an input, 1 bit wide, and synchronously clears ovf_count_o.
REQ-015 Port ovf_count_o SHALL be an output, 16 bits wide, and holds the count of overflowed words delivered.

Function
REQ-016 A transfer SHALL occur on an interface when valid and ready are both 1 at a rising clk_i.
REQ-017 The pipeline SHALL have two register stages: S1 = captured input plus overflow decode, and S2 = output register.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid_o, with no backpressure applied.
REQ-019 Throughput SHALL be one word per cycle while out_ready_i = 1.
REQ-020 S2 SHALL load from S1 when S2 is empty or an output transfer occurs.
REQ-021 S1 SHALL load from the input when S1 is empty or S1 is advancing.
REQ-022 in_ready_o SHALL equal (!S1.valid || S1 advancing); a combinational path from out_ready_i to in_ready_o is permitted.
REQ-023 Overflow SHALL be asserted when in_data_i > 2^(OUT_W-1)-1 or in_data_i < -2^(OUT_W-1), with both compares signed.
REQ-024 When sat_mode_i = 1 and there is positive overflow, the result SHALL be 0x7F (max); on negative overflow it SHALL be 0x80 (min).
REQ-025 When sat_mode_i = 0, the result SHALL be in_data_i[OUT_W-1:0] and out_ovf_o SHALL still report overflow.
REQ-026 When there is no overflow, the result SHALL be the low OUT_W bits in both modes, i.e. the exact sign-preserving value.
REQ-027 sat_mode_i SHALL be sampled together with in_data_i at input transfer and carried in S1.
REQ-028 While out_valid_o = 1 and out_ready_i = 0, out_data_o, out_ovf_o and out_valid_o SHALL hold stable.
REQ-029 No word SHALL be dropped or duplicated under any valid/ready pattern.
REQ-030 ovf_count_o SHALL increment by 1 on each output transfer with out_ovf_o = 1.
REQ-031 ovf_count_o SHALL saturate at 0xFFFF and SHALL not wrap.
REQ-032 If cnt_clr_i = 1 and an increment occur in the same cycle, clear SHALL win and the count SHALL become 0.

Reset
REQ-033 When rst_i = 1 at a rising clk_i, S1.valid, S2.valid, out_valid_o, out_data_o, out_ovf_o and ovf_count_o SHALL all become 0.
REQ-034 During a cycle with rst_i = 1, in_ready_o SHALL be 0.
REQ-035 In the first cycle after reset deassertion, in_ready_o SHALL be 1.
REQ-036 A reset asserted mid-stream SHALL discard all in-flight words, and no output transfer SHALL follow until new input is accepted.

Verification
REQ-037 With saturate mode, inputs 16'h0001 then 16'hFFFF SHALL yield 8'h01 with ovf=0, then 8'hFF with ovf=0, two cycles after each input.
REQ-038 With saturate mode, inputs 16'h0100 then 16'h8000 SHALL yield 8'h7F with ovf=1, then 8'h80 with ovf=1, and ovf_count_o = 2.
REQ-039 With wrap mode, inputs 16'hFF8A then 16'h0123 SHALL yield 8'h8A with ovf=0, then 8'h23 with ovf=1.
REQ-040 Streaming 10 words with out_ready_i toggled pseudo-randomly SHALL deliver all 10 in order, with output held stable while stalled, and in_ready_o = 0 only when both stages are full and stalled.
REQ-041 Raising cnt_clr_i in the same cycle as an overflowed output transfer SHALL leave ovf_count_o = 0.
REQ-042 Forcing 70000 overflowed transfers SHALL leave ovf_count_o = 16'hFFFF.
REQ-043 Asserting rst_i with 2 words in flight SHALL give out_valid_o = 0 and ovf_count_o = 0 on the next cycle, and neither word SHALL ever be emitted.

Source files
------------

// File: rtl/saturating_narrow.sv
// saturating_narrow: two-stage valid/ready pipeline that narrows a signed IN_W word
// to OUT_W bits, either saturating or wrapping, and counts overflowed outputs.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   in_valid_i   : input word present
//   in_data_i    : signed input word (IN_W)
//   in_ready_o   : input accepted this cycle
//   sat_mode_i   : 1 = saturate, 0 = wrap (truncate)
//   out_valid_o  : output word present
//   out_data_o   : narrowed signed result (OUT_W)
//   out_ovf_o    : input did not fit in OUT_W signed bits
//   out_ready_i  : consumer accepts output
//   cnt_clr_i    : synchronous clear of ovf_count_o
//   ovf_count_o  : saturating count of overflowed words delivered
module saturating_narrow #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [IN_W-1:0]  in_data_i,
    output logic             in_ready_o,
    input  logic             sat_mode_i,
    output logic             out_valid_o,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_ovf_o,
    input  logic             out_ready_i,
    input  logic             cnt_clr_i,
    output logic [15:0]      ovf_count_o
);
    logic             s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] s1_data_q, s1_data_d;
    logic             s1_sat_q, s1_sat_d;
    logic             s1_pos_q, s1_pos_d;
    logic             s1_neg_q, s1_neg_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             s2_load, in_ready;
    logic [IN_W-OUT_W:0] hi;

    always_comb begin
        s2_load = !out_valid_q || out_ready_i;
        in_ready = !rst_i && (!s1_valid_q || s2_load);
        // The value fits iff the sign bit and all bits down to OUT_W-1 agree.
        hi = in_data_i[IN_W-1:OUT_W-1];
        s1_valid_d = in_ready ? in_valid_i : s1_valid_q;
        s1_data_d = in_ready ? in_data_i[OUT_W-1:0] : s1_data_q;
        s1_sat_d = in_ready ? sat_mode_i : s1_sat_q;
        s1_pos_d = in_ready ? (!hi[IN_W-OUT_W] && (|hi)) : s1_pos_q;
        s1_neg_d = in_ready ? (hi[IN_W-OUT_W] && !(&hi)) : s1_neg_q;
        out_valid_d = s2_load ? s1_valid_q : out_valid_q;
        out_ovf_d = s2_load ? (s1_pos_q || s1_neg_q) : out_ovf_q;
        out_data_d = !s2_load ? out_data_q :
                     (s1_sat_q && s1_pos_q) ? {1'b0, {(OUT_W-1){1'b1}}} :
                     (s1_sat_q && s1_neg_q) ? {1'b1, {(OUT_W-1){1'b0}}} : s1_data_q;
        cnt_d = cnt_clr_i ? 16'd0 :
                (out_valid_q && out_ready_i && out_ovf_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sat_q    <= 1'b0;
            s1_pos_q    <= 1'b0;
            s1_neg_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sat_q    <= s1_sat_d;
            s1_pos_q    <= s1_pos_d;
            s1_neg_q    <= s1_neg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ovf_o   = out_ovf_q;
    assign ovf_count_o = cnt_q;
endmodule
